// File: rtl/boot_stream_sink_pkg.sv
// Shared types for the boot stream sink: record targets, FSM states and header field widths.
package boot_stream_sink_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int TGT_W  = 2;
  localparam int LEN_W  = 8;
  localparam int RSVD_W = DATA_W - TGT_W;

  typedef enum logic [TGT_W-1:0] {
    CONTROL       = 2'd0,
    MLU_SLICE     = 2'd1,
    MLU_LOOKAHEAD = 2'd2,
    END           = 2'd3
  } target_e;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    LEN,
    AHI,
    ALO,
    SETUP,
    STROBE,
    HOLD,
    DONE,
    ERR
  } state_e;

  typedef struct packed {
    logic [RSVD_W-1:0] rsvd;
    target_e           target;
  } hdr_t;

  // Upper header bits are reserved and must be zero in a well-formed image.
  function automatic logic hdr_valid(input hdr_t h);
    return h.rsvd == '0;
  endfunction

endpackage

// File: rtl/boot_stream_sink_if.sv
// Byte-stream input handshake plus RAM write bus and boot status of the boot stream sink.
// master = stream source / bus observer, slave = the sink itself.
interface boot_stream_sink_if;
  import boot_stream_sink_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              control_n_we;
  logic              mlu_slice_n_we;
  logic              mlu_lookahead_n_we;
  logic              n_booted;
  logic              boot_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_addr, wr_data, control_n_we, mlu_slice_n_we,
           mlu_lookahead_n_we, n_booted, boot_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_addr, wr_data, control_n_we, mlu_slice_n_we,
           mlu_lookahead_n_we, n_booted, boot_err
  );

endinterface

// File: rtl/boot_stream_sink_we_decode.sv
// Maps record target + strobe to the three active-low write enables; combinational, no backpressure.
// At most one line is ever low; the end-of-image target drives none.
module boot_we_decode
  import boot_stream_sink_pkg::*;
(
  input  target_e target,
  input  logic    strobe,
  output logic    control_n_we,
  output logic    mlu_slice_n_we,
  output logic    mlu_lookahead_n_we
);

  always_comb begin
    control_n_we       = 1'b1;
    mlu_slice_n_we     = 1'b1;
    mlu_lookahead_n_we = 1'b1;
    if (strobe) begin
      case (target)
        CONTROL:       control_n_we       = 1'b0;
        MLU_SLICE:     mlu_slice_n_we     = 1'b0;
        MLU_LOOKAHEAD: mlu_lookahead_n_we = 1'b0;
        default:       ;
      endcase
    end
  end

endmodule

// File: rtl/boot_stream_sink.sv
// Loads HDR/LEN/ADDR_HI/ADDR_LO/payload records into RAM as SETUP/STROBE/HOLD writes (3 cycles per byte);
// in_ready only in header states and HOLD with bytes left. BOOT_CHECKSUM_EN adds a zero-sum byte after the end record.
module boot_stream_sink
  import boot_stream_sink_pkg::*;
#(
  parameter int MAX_LEN = 256
) (
  input logic               clk,
  input logic               n_rst,
  boot_stream_sink_if.slave bus
);

  localparam int              CNT_W   = LEN_W + 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_e            state_q, state_d, hdr_next;
  target_e           tgt_q;
  hdr_t              hdr_in;
  logic [DATA_W-1:0] addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [LEN_W:0]    rem_q;
  logic [CNT_W-1:0]  len_total;
  logic              in_ready;
  logic              accept;

  assign hdr_in    = hdr_t'(bus.in_data);
  assign len_total = CNT_W'(bus.in_data) + CNT_W'(1);
  assign accept    = bus.in_valid && in_ready;

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  logic              csum_phase_q;

  // After the end record the next byte in HDR position is the checksum.
  always_comb begin
    hdr_next = LEN;
    if (csum_phase_q)
      hdr_next = (DATA_W'(sum_q + bus.in_data) == '0) ? DONE : ERR;
    else if (!hdr_valid(hdr_in))
      hdr_next = ERR;
    else if (hdr_in.target == END)
      hdr_next = HDR;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sum_q        <= '0;
      csum_phase_q <= 1'b0;
    end else if (accept) begin
      sum_q <= sum_q + bus.in_data;
      if (state_q == HDR && hdr_next == HDR)
        csum_phase_q <= 1'b1;
    end
  end
`else
  always_comb begin
    hdr_next = LEN;
    if (!hdr_valid(hdr_in))
      hdr_next = ERR;
    else if (hdr_in.target == END)
      hdr_next = DONE;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: state_d = HDR;
      HDR: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = hdr_next;
      end
      LEN: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = (len_total > MAX_CNT) ? ERR : AHI;
      end
      AHI: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = ALO;
      end
      // The first payload byte is taken in HOLD, so every byte sees SETUP/STROBE/HOLD.
      ALO: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = HOLD;
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (rem_q != '0) begin
          in_ready = 1'b1;
          if (bus.in_valid) state_d = SETUP;
        end else begin
          state_d = HDR;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tgt_q     <= CONTROL;
      addr_hi_q <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (accept) begin
      case (state_q)
        HDR: tgt_q     <= hdr_in.target;
        LEN: rem_q     <= len_total[LEN_W:0];
        AHI: addr_hi_q <= bus.in_data;
        ALO: addr_q    <= {addr_hi_q, bus.in_data};
        HOLD: begin
          wr_addr_q <= addr_q;
          wr_data_q <= bus.in_data;
          addr_q    <= addr_q + 1'b1;
          rem_q     <= rem_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobe is decoded straight from the state register so reset clears it asynchronously.
  boot_we_decode u_we_decode (
    .target             (tgt_q),
    .strobe             (state_q == STROBE),
    .control_n_we       (bus.control_n_we),
    .mlu_slice_n_we     (bus.mlu_slice_n_we),
    .mlu_lookahead_n_we (bus.mlu_lookahead_n_we)
  );

  assign bus.in_ready = in_ready;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.n_booted = (state_q != DONE);
  assign bus.boot_err = (state_q == ERR);

endmodule

// File: doc/boot_stream_sink.md
BOOT_STREAM_SINK -- requirements
Module: boot_stream_sink

Interface
REQ-001 SHALL have ports: CLK in 1, system clock; all state on rising edge.
REQ-002 SHALL have ports: N_RST in 1, asynchronous, active-low reset.
REQ-003 SHALL have ports: IN_DATA in 8, boot stream byte from the EEPROM image; IN_VALID in 1, byte present; IN_READY out 1, byte accepted when IN_VALID&&IN_READY at CLK rise.
REQ-004 SHALL have ports: WR_ADDR out 16, target RAM address; WR_DATA out 8, target RAM data.
REQ-005 SHALL have ports: CONTROL_N_WE, MLU_SLICE_N_WE, MLU_LOOKAHEAD_N_WE out 1 each, active-low write strobes.
REQ-006 SHALL have ports: N_BOOTED out 1, low once the image has been fully loaded; BOOT_ERR out 1, sticky error flag.
REQ-007 SHALL have parameter: MAX_LEN, default 256, maximum payload bytes per record.

Function
REQ-008 Stream SHALL be records of the form HDR, LEN, ADDR_HI, ADDR_LO, then LEN+1 payload bytes; HDR[1:0] selects the target: 0=control, 1=MLU slice, 2=MLU lookahead, 3=end-of-image. Any record with HDR[1:0]=3 carries no further bytes.
REQ-009 FSM states SHALL be IDLE, HDR, LEN, AHI, ALO, SETUP, STROBE, HOLD, DONE, ERR.
REQ-010 IDLE->HDR SHALL occur on the first cycle after reset release.
REQ-011 HDR/LEN/AHI/ALO SHALL each consume one accepted byte; IN_READY SHALL be high only in HDR, LEN, AHI, ALO and HOLD-with-bytes-remaining.
REQ-012 Each payload byte SHALL take exactly 3 cycles:
- SETUP: WR_ADDR/WR_DATA stable, all N_WE high.
- STROBE: the selected N_WE low for exactly one cycle.
- HOLD: N_WE high, address/data held.
REQ-013 WR_ADDR SHALL increment by 1 after each payload byte and wrap 0xFFFF->0x0000 without error.
REQ-014 The record SHALL end after LEN+1 bytes; HOLD SHALL then go to HDR.
REQ-015 HDR=end SHALL go to DONE; DONE SHALL drive N_BOOTED low, hold IN_READY low and hold every N_WE high until reset.
REQ-016 LEN+1>MAX_LEN or HDR[7:2]!=0 SHALL go to ERR: BOOT_ERR=1, N_BOOTED stays high, no further strobes, IN_READY low.
REQ-017 IN_VALID low in any byte-consuming state SHALL stall the FSM with all outputs held; no strobe SHALL issue on a stalled byte.
REQ-018 At most one N_WE SHALL be low in any cycle.

Reset
REQ-019 Reset SHALL set: state IDLE, IN_READY 0, WR_ADDR 0, WR_DATA 0, all N_WE 1, N_BOOTED 1, BOOT_ERR 0.
REQ-020 Reset asserted mid-STROBE SHALL deassert the N_WE immediately (asynchronously); the partial record is discarded.

Configuration
REQ-021 BOOT_CHECKSUM_EN defined: an 8-bit sum of all bytes (mod 256) SHALL be kept; the end record SHALL be followed by one checksum byte making the total 0; a mismatch SHALL go to ERR, otherwise DONE.
REQ-022 BOOT_CHECKSUM_EN undefined: there SHALL be no checksum byte; the end record SHALL go directly to DONE.

Structure
REQ-023 A shared package SHALL hold the target enum (CONTROL, MLU_SLICE, MLU_LOOKAHEAD, END), the FSM state enum and the header field widths.
REQ-024 One sub-module, boot_we_decode, SHALL map target + strobe to the three active-low N_WE lines, one-hot or none.

Verification
REQ-025 Record {0x00,0x01,0x12,0x34,0xAA,0xBB} then {0x03} -> CONTROL_N_WE pulses twice, 3 cycles apart, at 0x1234/0xAA and 0x1235/0xBB; N_BOOTED falls after the end record.
REQ-026 Target 2 with ADDR 0xFFFF, LEN=1 -> MLU_LOOKAHEAD_N_WE writes at 0xFFFF then 0x0000; BOOT_ERR stays 0.
REQ-027 IN_VALID dropped for 5 cycles mid-payload -> no strobe during the gap; write sequence and timing intact after resume.
REQ-028 HDR=0x04 -> BOOT_ERR=1, N_BOOTED stays 1, no N_WE ever low.
REQ-029 N_RST pulled low during STROBE -> N_WE high same cycle; after release the stream restarts at HDR.
REQ-030 With BOOT_CHECKSUM_EN, a wrong final byte -> BOOT_ERR=1; the correct byte -> N_BOOTED=0.
